// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: the pattern select changes only on a VGA_VS
// falling edge, either every DWELL frames (auto) or once per debounced button press (manual).
`timescale 1ns/1ps

// state     | meaning
// ST_SYNC   | after reset, waiting for the first frame boundary
// ST_AUTO   | advance every DWELL frames
// ST_MANUAL | advance on a frame boundary when a press is pending
module vga_pattern_sched #(
    parameter int NPAT    = 8,
    parameter int DWELL   = 60,
    parameter int DEB_CYC = 1250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VGA_VS,
    input  logic       BTN,
    input  logic       AUTO,
    output logic [2:0] PAT_SEL,
    output logic       FRAME_TICK,
    output logic       PAT_CHG,
    output logic [1:0] MODE
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_AUTO   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    localparam logic [20:0] DEB_LAST   = 21'(DEB_CYC - 1);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);
    localparam logic [2:0]  PAT_LAST   = 3'(NPAT - 1);

    logic [1:0]  vs_sync;
    logic [1:0]  btn_sync;
    logic [1:0]  auto_sync;
    logic        vs_prev;
    logic        tick;
    logic        vs_fall;
    logic [20:0] deb_cnt;
    logic        btn_db;
    logic        btn_db_q;
    logic        press;

    state_t      state, state_n;
    logic [2:0]  pat_sel, pat_n, pat_inc;
    logic [7:0]  frame_cnt, cnt_n;
    logic        pending, pend_n;
    logic        pat_chg, chg_n;

    // The FSM acts on the same edge that raises tick, so PAT_SEL/PAT_CHG line up with FRAME_TICK.
    assign vs_fall = vs_prev & ~vs_sync[1];
    assign press   = btn_db & ~btn_db_q;
    assign pat_inc = (pat_sel == PAT_LAST) ? 3'd0 : pat_sel + 3'd1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vs_sync   <= 2'b11;
            btn_sync  <= 2'b00;
            auto_sync <= 2'b00;
            vs_prev   <= 1'b1;
            tick      <= 1'b0;
        end else begin
            vs_sync   <= {vs_sync[0], VGA_VS};
            btn_sync  <= {btn_sync[0], BTN};
            auto_sync <= {auto_sync[0], AUTO};
            vs_prev   <= vs_sync[1];
            tick      <= vs_fall;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            deb_cnt  <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_sync[1] == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_sync[1];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 21'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_SYNC;
            pat_sel   <= 3'd0;
            frame_cnt <= 8'd0;
            pending   <= 1'b0;
            pat_chg   <= 1'b0;
        end else begin
            state     <= state_n;
            pat_sel   <= pat_n;
            frame_cnt <= cnt_n;
            pending   <= pend_n;
            pat_chg   <= chg_n;
        end
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_sel;
        cnt_n   = frame_cnt;
        pend_n  = pending;
        chg_n   = 1'b0;
        if (vs_fall) begin
            case (state)
                ST_SYNC: begin
                    state_n = auto_sync[1] ? ST_AUTO : ST_MANUAL;
                    cnt_n   = 8'd0;
                end
                ST_AUTO: begin
                    if (!auto_sync[1]) begin
                        state_n = ST_MANUAL;
                        cnt_n   = 8'd0;
                        pend_n  = 1'b0;
                    end else if (frame_cnt == DWELL_LAST) begin
                        pat_n = pat_inc;
                        chg_n = 1'b1;
                        cnt_n = 8'd0;
                    end else begin
                        cnt_n = frame_cnt + 8'd1;
                    end
                end
                ST_MANUAL: begin
                    if (pending) begin
                        pat_n  = pat_inc;
                        chg_n  = 1'b1;
                        pend_n = 1'b0;
                    end
                    if (auto_sync[1]) begin
                        state_n = ST_AUTO;
                        cnt_n   = 8'd0;
                    end
                end
                default: begin
                    state_n = ST_SYNC;
                    cnt_n   = 8'd0;
                end
            endcase
        end
        // A press landing on a tick re-arms pending after the tick has consumed the old one.
        if (press && state == ST_MANUAL) begin
            pend_n = 1'b1;
        end
    end

    assign PAT_SEL    = pat_sel;
    assign FRAME_TICK = tick;
    assign PAT_CHG    = pat_chg;
    assign MODE       = state;

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Bench for vga_pattern_sched: frame-timed scenarios plus random button/switch activity,
// compared every cycle against a frame/press-level reference model.
`timescale 1ns/1ps

module tb_vga_pattern_sched;

    localparam int NPAT    = 8;
    localparam int DWELL   = 3;
    localparam int DEB_CYC = 4;
    localparam int FRAME   = 200;
    localparam int VS_LOW  = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VGA_VS;
    logic       BTN;
    logic       AUTO;
    logic [2:0] PAT_SEL;
    logic       FRAME_TICK;
    logic       PAT_CHG;
    logic [1:0] MODE;

    vga_pattern_sched #(.NPAT(NPAT), .DWELL(DWELL), .DEB_CYC(DEB_CYC)) dut (
        .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .BTN(BTN), .AUTO(AUTO),
        .PAT_SEL(PAT_SEL), .FRAME_TICK(FRAME_TICK), .PAT_CHG(PAT_CHG), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int fc = 0;
    int n_chg = 0;
    int n_lone = 0;
    int n_tick = 0;

    // reference model: input histories, debounced level, mode/pattern/dwell/pending
    bit vs_h[$];
    bit bt_h[$];
    bit au_h[$];
    int m_mode, m_pat, m_cnt, m_run;
    bit m_pend, m_db, m_rose, m_tick, m_chg;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        vs_h = '{1'b1, 1'b1, 1'b1, 1'b1};
        bt_h = '{1'b0, 1'b0, 1'b0, 1'b0};
        au_h = '{1'b0, 1'b0, 1'b0, 1'b0};
        m_mode = 0; m_pat = 0; m_cnt = 0; m_run = 0;
        m_pend = 0; m_db = 0; m_rose = 0; m_tick = 0; m_chg = 0;
    endtask

    task automatic advance();
        m_pat = (m_pat + 1) % NPAT;
        m_chg = 1;
    endtask

    task automatic model_edge();
        bit tick, bs, as_, press, was_manual;
        vs_h.push_front(VGA_VS); void'(vs_h.pop_back());
        bt_h.push_front(BTN);    void'(bt_h.pop_back());
        au_h.push_front(AUTO);   void'(au_h.pop_back());
        tick = vs_h[3] && !vs_h[2];
        bs   = bt_h[2];
        as_  = au_h[2];
        press = m_rose;
        m_rose = 0;
        if (bs != m_db) begin
            m_run++;
            if (m_run == DEB_CYC) begin
                m_db = bs;
                m_run = 0;
                m_rose = bs;
            end
        end else begin
            m_run = 0;
        end
        m_chg = 0;
        was_manual = (m_mode == 2);
        if (tick) begin
            case (m_mode)
                0: begin m_mode = as_ ? 1 : 2; m_cnt = 0; end
                1: begin
                    if (!as_) begin m_mode = 2; m_cnt = 0; m_pend = 0; end
                    else if (m_cnt == DWELL - 1) begin advance(); m_cnt = 0; end
                    else m_cnt++;
                end
                default: begin
                    if (m_pend) begin advance(); m_pend = 0; end
                    if (as_) begin m_mode = 1; m_cnt = 0; end
                end
            endcase
        end
        if (press && was_manual) m_pend = 1;
        m_tick = tick;
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) model_edge();
        else model_reset();
        @(negedge CLK);
        chk("pat_sel", PAT_SEL, m_pat);
        chk("frame_tick", FRAME_TICK, m_tick);
        chk("pat_chg", PAT_CHG, m_chg);
        chk("mode", MODE, m_mode);
        if (PAT_CHG) n_chg++;
        if (PAT_CHG && !FRAME_TICK) n_lone++;
        if (FRAME_TICK) n_tick++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            VGA_VS = (fc < VS_LOW) ? 1'b0 : 1'b1;
            step();
            fc = (fc + 1) % FRAME;
        end
    endtask

    task automatic run_to(input int f);
        while (fc != f) run(1);
    endtask

    task automatic press_btn(input int len);
        BTN = 1'b1;
        run(len);
        BTN = 1'b0;
        run(len);
    endtask

    initial begin
        RST = 1'b0; BTN = 1'b0; AUTO = 1'b1; VGA_VS = 1'b1;
        model_reset();
        #1;
        chk("reset_sel", PAT_SEL, 0);
        chk("reset_mode", MODE, 0);
        chk("reset_tick", FRAME_TICK, 0);
        chk("reset_chg", PAT_CHG, 0);
        run(20);

        // release mid-frame; SYNC until the first VS fall, no change there
        run_to($urandom_range(40, 150));
        RST = 1'b1;
        run_to(2);
        chk("sync_mode_hold", MODE, 0);
        chk("tick_not_early", FRAME_TICK, 0);
        run_to(3);
        chk("first_tick", FRAME_TICK, 1);
        chk("sync_to_auto", MODE, 1);
        chk("sync_no_chg", PAT_CHG, 0);

        // auto dwell and wrap over 25 frames
        n_chg = 0; n_lone = 0; n_tick = 0;
        run(25 * FRAME);
        chk("auto_chg_count", n_chg, 8);
        chk("chg_without_tick", n_lone, 0);
        chk("tick_count", n_tick, 25);
        chk("auto_wrap_sel", PAT_SEL, 0);

        // auto -> manual mid-dwell
        run_to(50);
        AUTO = 1'b0;
        run_to(3);
        chk("to_manual_mode", MODE, 2);
        chk("to_manual_sel", PAT_SEL, 0);

        // short glitch rejected
        run_to(60);
        BTN = 1'b1;
        run($urandom_range(1, 3));
        BTN = 1'b0;
        run_to(3);
        chk("glitch_sel", PAT_SEL, 0);

        // valid press applied at the next tick only
        run_to($urandom_range(40, 90));
        press_btn(10);
        run_to(199);
        chk("press_before_tick", PAT_SEL, 0);
        run_to(3);
        chk("press_at_tick", PAT_SEL, 1);
        chk("press_chg", PAT_CHG, 1);

        // three presses in one frame collapse
        run_to(20);
        repeat (3) begin
            BTN = 1'b1;
            run($urandom_range(6, 10));
            BTN = 1'b0;
            run($urandom_range(8, 16));
        end
        run_to(3);
        chk("three_press_sel", PAT_SEL, 2);

        // pending press, then a press landing on the tick edge
        run_to(30);
        press_btn(10);
        run_to(196);
        BTN = 1'b1;
        run_to(3);
        chk("collide_sel", PAT_SEL, 3);
        run(3);
        BTN = 1'b0;
        run_to(3);
        chk("collide_next_sel", PAT_SEL, 4);

        // manual -> auto with pending set
        run_to(60);
        press_btn(10);
        run_to(100);
        AUTO = 1'b1;
        run_to(3);
        chk("to_auto_sel", PAT_SEL, 5);
        chk("to_auto_mode", MODE, 1);
        run_to(60);
        press_btn(10);
        run_to(3);
        chk("auto_ignore_press", PAT_SEL, 5);
        run(FRAME);
        chk("auto_dwell_hold", PAT_SEL, 5);
        run(FRAME);
        chk("auto_third_tick", PAT_SEL, 6);

        // asynchronous reset between edges
        run_to(80);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_sel", PAT_SEL, 0);
        chk("async_rst_mode", MODE, 0);
        chk("async_rst_chg", PAT_CHG, 0);
        chk("async_rst_tick", FRAME_TICK, 0);
        model_reset();
        run($urandom_range(5, 30));
        RST = 1'b1;
        run_to(3);
        chk("post_rst_chg", PAT_CHG, 0);
        chk("post_rst_mode", MODE, 1);

        // random button and switch activity
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0) BTN = ~BTN;
            if ($urandom_range(0, 599) == 0) AUTO = ~AUTO;
            run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
